// File: rtl/mixer_lo_sequencer.sv
// rtl/mixer_lo_sequencer.sv - quadrature LO code sequencer with phase-hold divider; optional sideband select under MIXER_LO_SSB_EN
module mixer_lo_sequencer #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef MIXER_LO_SSB_EN
  input  logic             cfg_lsb,
`endif
  output logic [1:0]       LO_i,
  output logic [1:0]       LO_q,
  output logic             lo_strobe,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;

  state_t           state, state_n;
  logic [1:0]       phase, phase_n;
  logic [DIV_W-1:0] tick, tick_n;
  logic [DIV_W-1:0] div_r;
  logic             lsb_r;
  logic             active;
  logic             boundary;
  logic             cfg_fire;

  assign active    = (state != IDLE);
  // Last clock of the last phase: the only place a new period may be reconfigured.
  assign boundary  = active && (phase == 2'd3) && (tick == div_r);
  assign cfg_ready = !active || boundary;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = active;
  assign lo_strobe = active && (phase == 2'd0) && (tick == '0);

  // State, phase and hold counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      phase <= 2'd0;
      tick  <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      tick  <= tick_n;
    end
  end

  // Configuration registers; a handshake only completes in IDLE or on a boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_r <= DIV_W'(DIV_RESET);
    end else if (cfg_fire) begin
      div_r <= cfg_div;
    end
  end

`ifdef MIXER_LO_SSB_EN
  // Sideband select travels with the divider through the same handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      lsb_r <= 1'b0;
    end else if (cfg_fire) begin
      lsb_r <= cfg_lsb;
    end
  end
`else
  assign lsb_r = 1'b0;
`endif

  // Next-state logic: counters keep running through DRAIN so a re-request is glitch free.
  always_comb begin
    state_n = state;
    phase_n = phase;
    tick_n  = tick;
    case (state)
      IDLE: begin
        if (run) begin
          state_n = RUN;
          phase_n = 2'd0;
          tick_n  = '0;
        end
      end
      RUN, DRAIN: begin
        if (tick == div_r) begin
          tick_n  = '0;
          phase_n = phase + 2'd1;
        end else begin
          tick_n  = tick + 1'b1;
        end
        if (boundary) begin
          state_n = run ? RUN : IDLE;
        end else if (state == RUN && !run) begin
          state_n = DRAIN;
        end else if (state == DRAIN && run) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = 2'd0;
        tick_n  = '0;
      end
    endcase
  end

  // Phase decode from registered state only; lower sideband mirrors Q in phases 1 and 3.
  always_comb begin
    LO_i = CODE_ZERO;
    LO_q = CODE_ZERO;
    if (active) begin
      case (phase)
        2'd0: LO_i = CODE_POS;
        2'd1: LO_q = lsb_r ? CODE_NEG : CODE_POS;
        2'd2: LO_i = CODE_NEG;
        default: LO_q = lsb_r ? CODE_POS : CODE_NEG;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_lo_sequencer.sv
// tb/tb_mixer_lo_sequencer.sv - self-checking bench for mixer_lo_sequencer
module tb_mixer_lo_sequencer;

  localparam int DIV_W     = 8;
  localparam int DIV_RESET = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             run;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
`ifdef MIXER_LO_SSB_EN
  logic             cfg_lsb;
`endif
  logic [1:0]       LO_i;
  logic [1:0]       LO_q;
  logic             lo_strobe;
  logic             busy;

  int checks = 0;
  int errors = 0;

  mixer_lo_sequencer #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
`ifdef MIXER_LO_SSB_EN
    .cfg_lsb   (cfg_lsb),
`endif
    .LO_i      (LO_i),
    .LO_q      (LO_q),
    .lo_strobe (lo_strobe),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Reference model: position within the current LO period, active flag and period divider.
  bit m_active;
  int m_pos;
  int m_div;
  bit m_lsb;

  function automatic int m_last();
    return 4 * (m_div + 1) - 1;
  endfunction

  function automatic bit m_ready();
    return !m_active || (m_pos == m_last());
  endfunction

  function automatic logic [1:0] m_exp_i();
    int ph;
    ph = m_pos / (m_div + 1);
    if (!m_active) return 2'b00;
    if (ph == 0) return 2'b01;
    if (ph == 2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_exp_q();
    int ph;
    ph = m_pos / (m_div + 1);
    if (!m_active) return 2'b00;
    if (ph == 1) return m_lsb ? 2'b10 : 2'b01;
    if (ph == 3) return m_lsb ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_div    <= DIV_RESET;
      m_lsb    <= 1'b0;
    end else begin
      if (cfg_valid && m_ready()) begin
        m_div <= int'(cfg_div);
`ifdef MIXER_LO_SSB_EN
        m_lsb <= cfg_lsb;
`endif
      end
      if (!m_active) begin
        if (run) begin
          m_active <= 1'b1;
          m_pos    <= 0;
        end
      end else if (m_pos == m_last()) begin
        m_pos    <= 0;
        m_active <= run;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cyc();
    cyc();
    checks++; if (LO_i !== 2'b00) begin errors++; $display("FAIL reset_lo_i got %b want 00", LO_i); end
    checks++; if (LO_q !== 2'b00) begin errors++; $display("FAIL reset_lo_q got %b want 00", LO_q); end
    checks++; if (lo_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", lo_strobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic_div1();
    logic [1:0] ti [8];
    logic [1:0] tq [8];
    ti = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    tq = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
    do_reset();
    cfg_div   = 8'd1;
    cfg_valid = 1'b1;
    run       = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (LO_i !== ti[k%8]) begin errors++; $display("FAIL basic_lo_i[%0d] got %b want %b", k, LO_i, ti[k%8]); end
      checks++; if (LO_q !== tq[k%8]) begin errors++; $display("FAIL basic_lo_q[%0d] got %b want %b", k, LO_q, tq[k%8]); end
      checks++; if (lo_strobe !== (k % 8 == 0)) begin errors++; $display("FAIL basic_strobe[%0d] got %b want %b", k, lo_strobe, (k % 8 == 0)); end
      cyc();
    end
  endtask

  task automatic test_cfg_midperiod();
    do_reset();
    cfg_div   = 8'd0;
    cfg_valid = 1'b1;
    run       = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pos0 got %b want 0", cfg_ready); end
    cfg_div   = 8'd2;
    cfg_valid = 1'b1;
    cyc();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pos1 got %b want 0", cfg_ready); end
    cyc();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pos2 got %b want 0", cfg_ready); end
    cyc();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_pos3 got %b want 1", cfg_ready); end
    cyc();
    cfg_valid = 1'b0;
    checks++; if (lo_strobe !== 1'b1) begin errors++; $display("FAIL mid_new_period_strobe got %b want 1", lo_strobe); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++; if (lo_strobe !== (i == 12)) begin errors++; $display("FAIL mid_period12_strobe[%0d] got %b want %b", i, lo_strobe, (i == 12)); end
      if (i == 11) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_last12 got %b want 1", cfg_ready); end
      end
    end
  endtask

  task automatic test_stop_drain();
    do_reset();
    run = 1'b1;
    cyc();
    repeat (4) cyc();
    checks++; if (LO_q !== 2'b01) begin errors++; $display("FAIL drain_phase1_q got %b want 01", LO_q); end
    run = 1'b0;
    for (int p = 5; p <= 15; p++) begin
      cyc();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy[%0d] got %b want 1", p, busy); end
    end
    checks++; if (LO_q !== 2'b10) begin errors++; $display("FAIL drain_last_q got %b want 10", LO_q); end
    cyc();
    checks++; if (LO_i !== 2'b00) begin errors++; $display("FAIL drain_end_i got %b want 00", LO_i); end
    checks++; if (LO_q !== 2'b00) begin errors++; $display("FAIL drain_end_q got %b want 00", LO_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_end_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run = 1'b1;
    cyc();
    repeat (8) cyc();
    checks++; if (LO_i !== 2'b10) begin errors++; $display("FAIL b2b_phase2_i got %b want 10", LO_i); end
    run = 1'b0;
    repeat (4) cyc();
    checks++; if (LO_q !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL b2b_phase3 got q=%b busy=%b want q=10 busy=1", LO_q, busy); end
    run = 1'b1;
    repeat (4) cyc();
    checks++; if (lo_strobe !== 1'b1) begin errors++; $display("FAIL b2b_restart_strobe got %b want 1", lo_strobe); end
    checks++; if (LO_i !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got i=%b busy=%b want i=01 busy=1", LO_i, busy); end
    repeat (16) cyc();
    checks++; if (lo_strobe !== 1'b1) begin errors++; $display("FAIL b2b_next_strobe got %b want 1", lo_strobe); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    cfg_div   = 8'd1;
    cfg_valid = 1'b1;
    run       = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    repeat (4) cyc();
    checks++; if (LO_i !== 2'b10) begin errors++; $display("FAIL rst_mid_phase2_i got %b want 10", LO_i); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (LO_i !== 2'b00 || LO_q !== 2'b00) begin errors++; $display("FAIL rst_mid_lo got i=%b q=%b want 00 00", LO_i, LO_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", cfg_ready); end
    run = 1'b1;
    cyc();
    checks++; if (lo_strobe !== 1'b1) begin errors++; $display("FAIL rst_mid_start_strobe got %b want 1", lo_strobe); end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++; if (lo_strobe !== (i == 16)) begin errors++; $display("FAIL rst_mid_div3_strobe[%0d] got %b want %b", i, lo_strobe, (i == 16)); end
    end
  endtask

`ifdef MIXER_LO_SSB_EN
  task automatic test_ssb();
    logic [1:0] tq [4];
    tq = '{2'b00, 2'b10, 2'b00, 2'b01};
    do_reset();
    cfg_div   = 8'd0;
    cfg_lsb   = 1'b1;
    cfg_valid = 1'b1;
    run       = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (LO_q !== tq[k%4]) begin errors++; $display("FAIL ssb_lo_q[%0d] got %b want %b", k, LO_q, tq[k%4]); end
      cyc();
    end
    cfg_lsb = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      checks++; if (LO_i !== m_exp_i()) begin errors++; $display("FAIL rand_lo_i[%0d] got %b want %b", n, LO_i, m_exp_i()); end
      checks++; if (LO_q !== m_exp_q()) begin errors++; $display("FAIL rand_lo_q[%0d] got %b want %b", n, LO_q, m_exp_q()); end
      checks++; if (lo_strobe !== (m_active && m_pos == 0)) begin errors++; $display("FAIL rand_strobe[%0d] got %b want %b", n, lo_strobe, (m_active && m_pos == 0)); end
      checks++; if (busy !== m_active) begin errors++; $display("FAIL rand_busy[%0d] got %b want %b", n, busy, m_active); end
      checks++; if (cfg_ready !== m_ready()) begin errors++; $display("FAIL rand_cfg_ready[%0d] got %b want %b", n, cfg_ready, m_ready()); end
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) run = ~run;
      if (!(cfg_valid && !m_ready())) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_div   = DIV_W'($urandom_range(0, 3));
`ifdef MIXER_LO_SSB_EN
        cfg_lsb   = 1'($urandom_range(0, 1));
`endif
      end
      cyc();
    end
    reset     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
`ifdef MIXER_LO_SSB_EN
    cfg_lsb   = 1'b0;
`endif
    test_reset();
    test_basic_div1();
    test_cfg_midperiod();
    test_stop_drain();
    test_back_to_back();
    test_reset_midop();
`ifdef MIXER_LO_SSB_EN
    test_ssb();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
